// File: rtl/cpu_if_pkg.sv
// Shared definitions for the instruction fetch stage: interrupt-injection
// state encodings and the instruction constants the fetch logic emits.
package cpu_if_pkg;

  typedef enum logic [1:0] {
    S_INT_IDLE = 2'd0,
    S_INT_WAIT = 2'd1,
    S_INT_IINS = 2'd2,
    S_INT_INOP = 2'd3
  } int_state_t;

  // All-zero word is the pipeline bubble.
  localparam logic [31:0] NOP = 32'h0000_0000;

  // JALR $i1, $i0 -- jumps to the vector held in $i0, saving the return in $i1.
  localparam logic [31:0] IV_INST_DEFAULT = 32'h0340_d809;

endpackage

// File: rtl/if_queue.sv
// Circular prefetch FIFO holding {pc, inst} pairs. Clear wins over push;
// a push into an empty queue becomes visible at the head one cycle later.
module if_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !clear && (!full || do_pop);

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cpu_if_pq.sv
// Instruction fetch stage with prefetch queue, one-outstanding memory
// handshake, redirect squash and interrupt-vector injection.
//
// int FSM states:
//   state      | meaning
//   S_INT_IDLE | no interrupt pending; int_req sampled
//   S_INT_WAIT | waiting for one real instruction to issue (delay-slot guard)
//   S_INT_IINS | inject IV_INST, flush queue, refetch from int_pc
//   S_INT_INOP | issue a bubble behind the injected jump
module cpu_if_pq
  import cpu_if_pkg::*;
#(
  parameter int                W_ADDR   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [W_ADDR-1:0] RESET_PC = '0,
  parameter logic [W_ADDR-1:0] IV_INST  = W_ADDR'(IV_INST_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_stall,
  input  logic              stall,
  output logic              imem_req,
  output logic [W_ADDR-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [W_ADDR-1:0] iin,
  input  logic [W_ADDR-1:0] b_addr,
  input  logic [W_ADDR-1:0] j_addr,
  input  logic              pc_b,
  input  logic              pc_j,
  output logic [W_ADDR-1:0] p_pc,
  output logic [W_ADDR-1:0] p_inst,
  input  logic              int_req,
  input  logic [W_ADDR-1:0] int_pc,
  output logic              int_ack,
  output logic              int_flush
);

  localparam int                CW   = $clog2(DEPTH) + 1;
  localparam logic [W_ADDR-1:0] BUBB = W_ADDR'(NOP);

  int_state_t          st, st_n;
  logic [W_ADDR-1:0]   fpc, redir_pc;
  logic                squash, req_q, seen_real;
  logic                redirect, inject, flush, ack_ok, pending;
  logic [W_ADDR-1:0]   new_pc;
  logic                q_push, q_pop, q_full, q_empty;
  logic [2*W_ADDR-1:0] q_dout;
  logic [CW-1:0]       q_count, cnt_n;

  // Injection owns the IINS cycle; redirects are honoured everywhere else.
  assign redirect = (pc_b || pc_j) && !cpu_stall && (st != S_INT_IINS);
  assign inject   = (st == S_INT_IINS) && !cpu_stall;
  assign flush    = redirect || inject;
  assign new_pc   = inject ? int_pc : (pc_b ? b_addr : j_addr);
  assign ack_ok   = req_q && imem_ack;
  assign pending  = req_q && !imem_ack;
  assign q_pop    = !cpu_stall && !stall && !flush &&
                    ((st == S_INT_IDLE) || (st == S_INT_WAIT));
  assign q_push   = ack_ok && !squash && (!q_full || q_pop);
  assign cnt_n    = flush ? '0 :
                    q_count + CW'(q_push) - CW'(q_pop && !q_empty);

  assign imem_req  = req_q;
  assign imem_addr = fpc;
  assign int_ack   = (st != S_INT_IDLE);
  assign int_flush = (st == S_INT_IINS);

  if_queue #(.DEPTH(DEPTH), .WIDTH(2*W_ADDR)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .clear (flush),
    .din   ({fpc, iin}),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Fetch address and request handshake; an in-flight request is never
  // retargeted, a flush behind it is parked in redir_pc until its ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc      <= RESET_PC;
      redir_pc <= RESET_PC;
      squash   <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      req_q <= pending || (cnt_n < CW'(DEPTH));
      if (flush && pending) begin
        squash   <= 1'b1;
        redir_pc <= new_pc;
      end else if (ack_ok) begin
        squash <= 1'b0;
      end
      if (flush && !pending)
        fpc <= new_pc;
      else if (ack_ok)
        fpc <= squash ? redir_pc : fpc + W_ADDR'(4);
    end
  end

  // IF/ID register: injection, squash, hold or pop (bubble when empty).
  always_ff @(posedge clk) begin
    if (rst) begin
      p_pc   <= BUBB;
      p_inst <= BUBB;
    end else if (!cpu_stall) begin
      if (inject) begin
        p_pc   <= BUBB;
        p_inst <= IV_INST;
      end else if (redirect || (st == S_INT_INOP)) begin
        p_pc   <= BUBB;
        p_inst <= BUBB;
      end else if (!stall) begin
        p_pc   <= q_empty ? BUBB : q_dout[2*W_ADDR-1:W_ADDR];
        p_inst <= q_empty ? BUBB : q_dout[W_ADDR-1:0];
      end
    end
  end

  // Tracks whether a real instruction has issued since entering WAIT.
  always_ff @(posedge clk) begin
    if (rst)
      seen_real <= 1'b0;
    else if (!cpu_stall) begin
      if (st != S_INT_WAIT)
        seen_real <= 1'b0;
      else if (q_pop && !q_empty)
        seen_real <= 1'b1;
    end
  end

  // Interrupt state register.
  always_ff @(posedge clk) begin
    if (rst) st <= S_INT_IDLE;
    else     st <= st_n;
  end

  // Interrupt next-state; frozen under cpu_stall.
  always_comb begin
    st_n = st;
    if (!cpu_stall) begin
      case (st)
        S_INT_IDLE: if (int_req) st_n = S_INT_WAIT;
        S_INT_WAIT: if (seen_real && !pc_b && !pc_j) st_n = S_INT_IINS;
        S_INT_IINS: st_n = S_INT_INOP;
        S_INT_INOP: st_n = S_INT_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_if_pq.md
Name: cpu_if_pq

Overview:
Parametrised instruction fetch stage with a prefetch queue and a variable-latency instruction-memory handshake. It decouples memory latency from the IF/ID pipeline register (p_pc/p_inst). It also handles branch/jump redirects, ID-stage stalls, global CPU stalls and interrupt-vector injection. It sits between the instruction memory/cache port and cpu_id.

Parameters:
W_ADDR, 32, address and instruction width
DEPTH, 4, prefetch queue entries (power of 2, >=2)
RESET_PC, 0, fetch address after reset
IV_INST, 32'h0340d809, injected interrupt-vector instruction (JALR $i1, $i0)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high; clock clk
cpu_stall  in  1  global freeze
stall  in  1  ID-stage hazard stall
imem_req  out  1  fetch request
imem_addr  out  W_ADDR  fetch address (fpc)
imem_ack  in  1  iin valid this cycle; request retired
iin  in  W_ADDR  fetched instruction
b_addr  in  W_ADDR  branch target
j_addr  in  W_ADDR  jump target
pc_b  in  1  branch taken
pc_j  in  1  jump taken
p_pc  out  W_ADDR  IF/ID pc
p_inst  out  W_ADDR  IF/ID instruction (0 = nop)
int  in  1  interrupt request
int_pc  in  W_ADDR  fetch resume address after injection
int_ack  out  1  injection in progress
int_flush  out  1  injection cycle; downstream squash

Behaviour:
- Reset: fpc=RESET_PC, queue empty, squash=0, imem_req=0, p_pc=0, p_inst=0, int_state=IDLE, int_ack=0, int_flush=0. Reset mid-request drops the request; any later ack is ignored while imem_req=0.
- Memory handshake:
  - At most one outstanding request.
  - imem_req is asserted when count + outstanding < DEPTH.
  - imem_addr and imem_req stay stable until imem_ack.
  - Data is captured in the ack cycle. On capture: push {fpc, iin} unless squash, then fpc += 4. Ack with zero wait is legal (req and ack in the same cycle).
- Issue:
  - When !cpu_stall && !stall, pop the queue head into p_pc/p_inst.
  - If the queue is empty, load a bubble (p_pc=0, p_inst=0).
  - Pop and push in the same cycle are allowed at full or empty; a push-through on empty takes one extra cycle (no bypass). Latency from ack to p_inst is 2 cycles.
- stall && no redirect: p_pc/p_inst and queue head hold; prefetch continues until full.
- Redirect (pc_b|pc_j, !cpu_stall):
  - Takes priority over stall. pc_b takes priority over pc_j.
  - Queue is cleared; p_pc/p_inst become 0; fpc becomes the target.
  - If a request is outstanding, squash=1: it completes at the old address, its data is dropped, and squash clears on that ack. The new request issues in the cycle after the ack.
- cpu_stall:
  - Freezes p_pc, p_inst, int_state and redirects.
  - An imem_ack during cpu_stall is still captured; the queue has space by construction.
- Interrupt FSM:
  - IDLE -> WAIT on int.
  - WAIT -> IINS once one real instruction (p_inst from queue, non-bubble) has issued since entry and there is no pc_b/pc_j this cycle. This protects the delay slot.
  - IINS -> INOP -> IDLE, each taking one non-cpu_stall cycle; a stall is ignored in these states.
  - IINS: p_inst=IV_INST, p_pc=0, queue cleared, fpc=int_pc, squash rule applies, int_flush=1.
  - INOP: p_inst=0, p_pc=0.
  - int_ack=1 in any state other than IDLE.
  - int is level-sensitive only in IDLE; the controller masks further interrupts itself.
- Arithmetic: fpc wraps modulo 2^W_ADDR. Queue pointers are log2(DEPTH) bits wide; count is log2(DEPTH)+1 bits.

Decomposition:
- Package cpu_if_pkg: S_INT_IDLE/WAIT/IINS/INOP encodings, NOP constant, default IV_INST.
- Sub-module if_queue: circular FIFO parametrised by DEPTH and width 2*W_ADDR, with push, pop, clear (clear wins over push), full, empty and count.

Test Plan:
- Reset, 1-cycle ack memory, no stall -> p_pc sequence 0,4,8,... from cycle 3; queue never exceeds DEPTH=4.
- Ack latency 3 cycles -> bubbles (p_inst=0) interleave; each instruction is issued exactly once, in order.
- stall held 6 cycles -> p_inst constant; imem_req drops once 4 entries are queued; on release, entries issue back-to-back.
- pc_b=1, b_addr=0x100, with a request outstanding at 0x20 -> the 0x20 data is dropped; next issued p_pc=0x100; no p_pc in 0x24–0x2C.
- int with int_pc=0x400 -> after one real issue: p_inst=0x0340d809, then 0, int_flush pulses 1 cycle; next fetch address 0x400.
- pc_j and stall in the same cycle, then cpu_stall during an ack -> redirect taken; the acked word is queued and issued after cpu_stall drops.
